tmu2_fetchvertex: RTL
=====================

# tmu2_fetchvertex

Vertex-fetch front end of the TMU2 texture-mapping pipeline, directly downstream of the TMU2 control interface. On `start` it walks the mesh square by square and reads the four corner vertices of each square over a Wishbone master. It emits one record per square: the corner texture coordinates plus the destination top-left position. It drives `busy` back to the control interface, which generates the completion IRQ from the falling edge.

## Interface
- Parameters: none.
- `sys_clk` in 1: clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle start pulse. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until the last record is acknowledged.
- `vertex_hlast`, `vertex_vlast` in 7 each: index of the last vertex column/row. Squares span x in 0..hlast-1 and y in 0..vlast-1.
- `vertex_adr` in 29: mesh base, in 8-byte units.
- `dst_hoffset`, `dst_voffset` in 12 signed: destination origin.
- `dst_squarew`, `dst_squareh` in 11: destination square size.
- `wbm_adr_o` out 32: byte address.
- `wbm_cti_o` out 3: cycle type.
- `wbm_cyc_o`, `wbm_stb_o` out 1.
- `wbm_ack_i` in 1.
- `wbm_dat_i` in 32.
- `pipe_stb_o` out 1: record valid.
- `pipe_ack_i` in 1: downstream accept.
- `ax ay bx by cx cy dx dy` out 18 signed each: corner texture coordinates, in the order A=(x,y), B=(x+1,y), C=(x,y+1), D=(x+1,y+1).
- `drx`, `dry` out 12 signed: destination top-left of the square.

## Operation
- Mesh layout:
  - Row stride is 128 vertices. Each vertex is 8 bytes: X word, then Y word.
  - Vertex (i,j) sits at byte address `{vertex_adr + {15'd0, j[6:0], i[6:0]}, 3'b000}`. The Y word is at +4.
  - The coordinate is word bits [17:0]; the upper bits are ignored.
- Inputs are sampled into internal registers on the accepted `start`. Later changes to the inputs have no effect until the next start.
- FSM states: IDLE → FETCH → EMIT → NEXT → FETCH … → IDLE.
  - IDLE: wait for `start`. If hlast==0 or vlast==0, `busy` is high for exactly one cycle, there is no bus activity and no record, and the FSM returns to IDLE.
  - FETCH: four 2-beat incrementing bursts, one per corner in order A, B, C, D.
    - Beat 0: `wbm_cti_o`=3'b010. Beat 1: 3'b111.
    - `wbm_cyc_o`/`wbm_stb_o` stay high across both beats of a burst and drop for one cycle between corners.
    - Each `wbm_ack_i` latches `wbm_dat_i[17:0]` into the current corner's X or Y register.
  - EMIT: `pipe_stb_o`=1 and all record outputs are stable. Leave when `pipe_stb_o & pipe_ack_i`.
  - NEXT: advance the square position and the destination accumulators.
    - Square position: x++. If x==hlast-1, set x=0 and y++. If y==vlast-1 at row end, go to IDLE and drop `busy`.
    - Destination accumulators: `drx += squarew` per column. At row end, `drx = hoffset` and `dry += squareh`. Start values are hoffset/voffset.
- Destination arithmetic is 12-bit two's complement. Wrap-around is silent and not flagged.
- `sys_rst` at any point aborts the mesh walk:
  - The FSM goes to IDLE.
  - An outstanding bus cycle is abandoned (`wbm_cyc_o` is low at the reset edge).
  - Any pending record is discarded.

## Timing
- Reset values of all outputs are 0: `busy`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_cti_o`, `wbm_adr_o`, `pipe_stb_o`, and all coordinates.
- `start` in cycle T puts the first `wbm_stb_o` in T+1, with `busy` high from T+1.
- With a zero-wait slave (ack in the same cycle as stb), one square costs 8 bus cycles plus 3 inter-corner gaps, then `pipe_stb_o` rises one cycle after the final ack.
- NEXT takes one cycle. The next FETCH starts the cycle after it.
- `busy` falls the cycle after the final EMIT handshake.
- `pipe_stb_o` is registered and may be held any number of cycles. The record does not change while it is waiting for `pipe_ack_i`.
- `wbm_*` outputs are registered.

## Structure
- Shared TMU2 package (constants only):
  - Mesh row stride log2 = 7.
  - CTI codes: incrementing burst = 3'b010, end of burst = 3'b111.
  - Coordinate width = 18.
- One natural sub-module: `tmu2_mesh_walker`.
  - Holds the x/y counters and the drx/dry accumulators, with `step` and `last` ports.
  - The top level holds the FSM, the Wishbone sequencing and the output registers.

## Test plan
- hlast=1, vlast=1, vertex_adr=0x100, zero-wait memory with X=i*16+j, Y=j*16+i:
  - Expect 4 bursts at 0x800, 0x808, 0xC00, 0xC08.
  - Expect one record: ax=0 ay=0, bx=16 by=1, cx=1 cy=16, dx=17 dy=17, drx=hoffset, dry=voffset.
  - `busy` then falls.
- hlast=3, vlast=2, squarew=16, squareh=8, hoffset=-5, voffset=10:
  - Expect 6 records.
  - drx sequence -5, 11, 27, -5, 11, 27. dry sequence 10, 10, 10, 18, 18, 18.
- hlast=0, vlast=24:
  - Expect one `busy` cycle, no `wbm_cyc_o`, no `pipe_stb_o`.
- `pipe_ack_i` held low for 20 cycles in EMIT:
  - Record is stable, no bus activity, the handshake completes on the first ack.
  - A second `start` pulsed meanwhile is ignored.
- Random 0–5 wait states on `wbm_ack_i`:
  - Records match the zero-wait run bit-for-bit.
  - `wbm_cti_o` is 010 then 111 within every burst.
- `sys_rst` asserted mid-burst on the 3rd square:
  - All outputs are 0 immediately (asynchronous).
  - After release, a new `start` fetches square 0 from the start.

Source files
------------

// File: rtl/tmu2_pkg.sv
// Shared TMU2 constants: mesh geometry, Wishbone burst codes and coordinate width.
package tmu2_pkg;

  localparam int MESH_STRIDE_LOG2 = 7;
  localparam int COORD_W          = 18;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

endpackage

// File: rtl/tmu2_mesh_walker.sv
// Square-position counters and destination accumulators for the vertex fetcher.
module tmu2_mesh_walker
  import tmu2_pkg::*;
(
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        load,
  input  logic                        step,
  input  logic [MESH_STRIDE_LOG2-1:0] hlast,
  input  logic [MESH_STRIDE_LOG2-1:0] vlast,
  input  logic signed [11:0]          hoffset,
  input  logic signed [11:0]          voffset,
  input  logic [10:0]                 squarew,
  input  logic [10:0]                 squareh,
  output logic [MESH_STRIDE_LOG2-1:0] x,
  output logic [MESH_STRIDE_LOG2-1:0] y,
  output logic signed [11:0]          drx,
  output logic signed [11:0]          dry,
  output logic                        last
);

  logic [MESH_STRIDE_LOG2-1:0] hlast_reg, vlast_reg, x_reg, y_reg;
  logic signed [11:0]          hoffset_reg, drx_reg, dry_reg;
  logic [10:0]                 squarew_reg, squareh_reg;
  logic                        row_end;

  assign row_end = (x_reg == hlast_reg - 1'b1);
  assign last    = row_end && (y_reg == vlast_reg - 1'b1);

  assign x   = x_reg;
  assign y   = y_reg;
  assign drx = drx_reg;
  assign dry = dry_reg;

  // Accumulators wrap silently in 12-bit two's complement.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hlast_reg   <= '0;
      vlast_reg   <= '0;
      hoffset_reg <= '0;
      squarew_reg <= '0;
      squareh_reg <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      drx_reg     <= '0;
      dry_reg     <= '0;
    end else if (load) begin
      hlast_reg   <= hlast;
      vlast_reg   <= vlast;
      hoffset_reg <= hoffset;
      squarew_reg <= squarew;
      squareh_reg <= squareh;
      x_reg       <= '0;
      y_reg       <= '0;
      drx_reg     <= hoffset;
      dry_reg     <= voffset;
    end else if (step) begin
      if (row_end) begin
        x_reg   <= '0;
        y_reg   <= y_reg + 1'b1;
        drx_reg <= hoffset_reg;
        dry_reg <= dry_reg + $signed({1'b0, squareh_reg});
      end else begin
        x_reg   <= x_reg + 1'b1;
        drx_reg <= drx_reg + $signed({1'b0, squarew_reg});
      end
    end
  end

endmodule

// File: rtl/tmu2_fetchvertex.sv
// TMU2 vertex fetch: reads the four corners of each mesh square over Wishbone
// bursts and presents one texture/destination record per square.
module tmu2_fetchvertex
  import tmu2_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  output logic               busy,
  input  logic [6:0]         vertex_hlast,
  input  logic [6:0]         vertex_vlast,
  input  logic [28:0]        vertex_adr,
  input  logic signed [11:0] dst_hoffset,
  input  logic signed [11:0] dst_voffset,
  input  logic [10:0]        dst_squarew,
  input  logic [10:0]        dst_squareh,
  output logic [31:0]        wbm_adr_o,
  output logic [2:0]         wbm_cti_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  input  logic               wbm_ack_i,
  input  logic [31:0]        wbm_dat_i,
  output logic               pipe_stb_o,
  input  logic               pipe_ack_i,
  output logic signed [17:0] ax,
  output logic signed [17:0] ay,
  output logic signed [17:0] bx,
  output logic signed [17:0] by,
  output logic signed [17:0] cx,
  output logic signed [17:0] cy,
  output logic signed [17:0] dx,
  output logic signed [17:0] dy,
  output logic signed [11:0] drx,
  output logic signed [11:0] dry
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, NEXT} state_t;

  state_t             state_reg, state_next;
  logic               busy_reg, busy_next;
  logic               cyc_reg, cyc_next;
  logic [31:0]        adr_reg, adr_next;
  logic [2:0]         cti_reg, cti_next;
  logic [1:0]         corner_reg, corner_next;
  logic               beat_reg, beat_next;
  logic               pipe_stb_reg, pipe_stb_next;
  logic [28:0]        base_reg;
  logic [COORD_W-1:0] coord_reg  [0:7];
  logic [COORD_W-1:0] coord_next [0:7];

  logic                        load, step, walk_last, degenerate;
  logic [MESH_STRIDE_LOG2-1:0] walk_x, walk_y;
  logic                        unused_dat;

  assign unused_dat = ^wbm_dat_i[31:COORD_W];
  assign degenerate = (vertex_hlast == '0) || (vertex_vlast == '0);

  tmu2_mesh_walker u_walker (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (load),
    .step    (step),
    .hlast   (vertex_hlast),
    .vlast   (vertex_vlast),
    .hoffset (dst_hoffset),
    .voffset (dst_voffset),
    .squarew (dst_squarew),
    .squareh (dst_squareh),
    .x       (walk_x),
    .y       (walk_y),
    .drx     (drx),
    .dry     (dry),
    .last    (walk_last)
  );

  // Corner c[0] selects the +1 column, c[1] the +1 row; hi selects the Y word.
  function automatic logic [31:0] corner_adr(input logic [28:0] base,
                                             input logic [6:0] px, input logic [6:0] py,
                                             input logic [1:0] c, input logic hi);
    logic [6:0]  ci, cj;
    logic [28:0] v;
    ci = px + {6'd0, c[0]};
    cj = py + {6'd0, c[1]};
    v  = base + {15'd0, cj, ci};
    return {v, hi, 2'b00};
  endfunction

  always_comb begin
    state_next    = state_reg;
    busy_next     = busy_reg;
    cyc_next      = cyc_reg;
    adr_next      = adr_reg;
    cti_next      = cti_reg;
    corner_next   = corner_reg;
    beat_next     = beat_reg;
    pipe_stb_next = pipe_stb_reg;
    coord_next    = coord_reg;
    load          = 1'b0;
    step          = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start && !busy_reg) begin
          load      = 1'b1;
          busy_next = 1'b1;
          if (!degenerate) begin
            // Walk restarts at square (0,0), so corner A sits at the base.
            state_next  = FETCH;
            cyc_next    = 1'b1;
            adr_next    = {vertex_adr, 3'b000};
            cti_next    = CTI_INCR;
            corner_next = 2'd0;
            beat_next   = 1'b0;
          end
        end
      end
      FETCH: begin
        if (!cyc_reg) begin
          cyc_next  = 1'b1;
          adr_next  = corner_adr(base_reg, walk_x, walk_y, corner_reg, 1'b0);
          cti_next  = CTI_INCR;
          beat_next = 1'b0;
        end else if (wbm_ack_i) begin
          coord_next[{corner_reg, beat_reg}] = wbm_dat_i[COORD_W-1:0];
          if (!beat_reg) begin
            beat_next = 1'b1;
            adr_next  = corner_adr(base_reg, walk_x, walk_y, corner_reg, 1'b1);
            cti_next  = CTI_END;
          end else begin
            cyc_next    = 1'b0;
            cti_next    = 3'b000;
            corner_next = corner_reg + 2'd1;
            if (corner_reg == 2'd3) begin
              state_next    = EMIT;
              pipe_stb_next = 1'b1;
            end
          end
        end
      end
      EMIT: begin
        if (pipe_ack_i) begin
          pipe_stb_next = 1'b0;
          state_next    = NEXT;
          busy_next     = !walk_last;
        end
      end
      NEXT: begin
        if (walk_last) begin
          state_next = IDLE;
        end else begin
          step        = 1'b1;
          state_next  = FETCH;
          corner_next = 2'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      cyc_reg      <= 1'b0;
      adr_reg      <= '0;
      cti_reg      <= '0;
      corner_reg   <= '0;
      beat_reg     <= 1'b0;
      pipe_stb_reg <= 1'b0;
      base_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      cyc_reg      <= cyc_next;
      adr_reg      <= adr_next;
      cti_reg      <= cti_next;
      corner_reg   <= corner_next;
      beat_reg     <= beat_next;
      pipe_stb_reg <= pipe_stb_next;
      if (load) base_reg <= vertex_adr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_coord
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) coord_reg[gi] <= '0;
        else         coord_reg[gi] <= coord_next[gi];
      end
    end
  endgenerate

  assign busy       = busy_reg;
  assign wbm_cyc_o  = cyc_reg;
  assign wbm_stb_o  = cyc_reg;
  assign wbm_adr_o  = adr_reg;
  assign wbm_cti_o  = cti_reg;
  assign pipe_stb_o = pipe_stb_reg;

  assign ax = coord_reg[0];
  assign ay = coord_reg[1];
  assign bx = coord_reg[2];
  assign by = coord_reg[3];
  assign cx = coord_reg[4];
  assign cy = coord_reg[5];
  assign dx = coord_reg[6];
  assign dy = coord_reg[7];

endmodule
